clk_div_bank: RTL and testbench

- Multi-channel, run-time programmable clock-enable/divider bank; generalises the fixed 8-bit ripple divider counter.
- Sits after the MMCM output buffer, clocked by the sampling clock.
- Each channel produces a 50%-duty divided signal, plus a one-cycle tick aligned to its rising edge.
- Ratio changes are glitch-free. A built-in startup counter holds all channels quiet after reset, as the MK_RST counter does.

---
 rtl/clk_div_bank.sv | 156 +++++++++++++++
 tb/tb_clk_div_bank.sv | 457 ++++++++++++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/clk_div_bank.sv
// clk_div_bank: run-time programmable bank of 50%-duty clock dividers.
//
// Each channel produces a divided output and a one-cycle tick on its rising
// edge. A startup counter holds every channel quiet after reset.
// New ratios are held in shadow registers and take effect only at a period
// boundary or on sync, so the output never glitches.
//
// Ports:
//   clk, rstn            sampling clock, async active-low reset
//   cfg_wr/cfg_ch        config write strobe and target channel
//   cfg_div/phase/en     new half-period-1, sync phase, enable
//   sync                 realign all channels to their phase values
//   div_out/tick/pend    per-channel output, rise tick, shadow pending
//   rst_out              high until the startup counter saturates
module clk_div_bank #(
    parameter int NCH     = 4,
    parameter int DIVW    = 8,
    parameter int DEF_DIV = 3,
    parameter bit DEF_EN  = 1'b1,
    parameter int RSTW    = 16
) (
    input  logic            clk,
    input  logic            rstn,
    input  logic            cfg_wr,
    input  logic [3:0]      cfg_ch,
    input  logic [DIVW-1:0] cfg_div,
    input  logic [DIVW-1:0] cfg_phase,
    input  logic            cfg_en,
    input  logic            sync,
    output logic [NCH-1:0]  div_out,
    output logic [NCH-1:0]  tick,
    output logic [NCH-1:0]  pend,
    output logic            rst_out
);

    localparam logic [DIVW-1:0] DEF_DIV_V = DIVW'(DEF_DIV);

    logic [RSTW-1:0] scnt_q, scnt_d;

    logic [DIVW-1:0] hcnt_q    [NCH];
    logic [DIVW-1:0] hcnt_d    [NCH];
    logic [DIVW-1:0] act_div_q [NCH];
    logic [DIVW-1:0] act_div_d [NCH];
    logic [DIVW-1:0] sh_div_q  [NCH];
    logic [DIVW-1:0] sh_div_d  [NCH];
    logic [DIVW-1:0] phase_q   [NCH];
    logic [DIVW-1:0] phase_d   [NCH];

    logic [NCH-1:0] en_q, en_d;
    logic [NCH-1:0] sh_en_q, sh_en_d;
    logic [NCH-1:0] div_q, div_d;
    logic [NCH-1:0] tick_q, tick_d;
    logic [NCH-1:0] pend_q, pend_d;
    logic [NCH-1:0] wr_hit;

    assign rst_out = ~(&scnt_q);
    assign div_out = div_q;
    assign tick    = tick_q;
    assign pend    = pend_q;

    // Indices at or above NCH match no channel, so such writes vanish.
    always_comb begin
        for (int i = 0; i < NCH; i++) begin
            wr_hit[i] = cfg_wr && (cfg_ch == 4'(i));
        end
    end

    always_comb begin
        scnt_d = (&scnt_q) ? scnt_q : scnt_q + 1'b1;
        for (int i = 0; i < NCH; i++) begin
            // A write lands in the shadow first, so anything applied
            // in this same cycle already sees the new value.
            sh_div_d[i]  = wr_hit[i] ? cfg_div   : sh_div_q[i];
            phase_d[i]   = wr_hit[i] ? cfg_phase : phase_q[i];
            sh_en_d[i]   = wr_hit[i] ? cfg_en    : sh_en_q[i];
            pend_d[i]    = pend_q[i] | wr_hit[i];
            act_div_d[i] = act_div_q[i];
            en_d[i]      = en_q[i];
            hcnt_d[i]    = hcnt_q[i];
            div_d[i]     = div_q[i];
            tick_d[i]    = 1'b0;

            if (rst_out) begin
                hcnt_d[i] = '0;
                div_d[i]  = 1'b0;
            end else if (sync) begin
                act_div_d[i] = sh_div_d[i];
                en_d[i]      = sh_en_d[i];
                pend_d[i]    = 1'b0;
                div_d[i]     = 1'b0;
                hcnt_d[i]    = '0;
                if (sh_en_d[i]) begin
                    hcnt_d[i] = (phase_d[i] < sh_div_d[i]) ?
                                phase_d[i] : sh_div_d[i];
                end
            end else if (!en_q[i]) begin
                // Idle channels have no boundary; apply one cycle
                // after the write instead.
                hcnt_d[i] = '0;
                div_d[i]  = 1'b0;
                if (pend_q[i]) begin
                    act_div_d[i] = sh_div_d[i];
                    en_d[i]      = sh_en_d[i];
                    pend_d[i]    = 1'b0;
                end
            end else if (hcnt_q[i] == act_div_q[i]) begin
                hcnt_d[i] = '0;
                if (div_q[i]) begin
                    div_d[i] = 1'b0;
                end else begin
                    // Period boundary: safe point to swap the ratio.
                    if (pend_d[i]) begin
                        act_div_d[i] = sh_div_d[i];
                        en_d[i]      = sh_en_d[i];
                        pend_d[i]    = 1'b0;
                    end
                    div_d[i]  = en_d[i];
                    tick_d[i] = en_d[i];
                end
            end else begin
                hcnt_d[i] = hcnt_q[i] + 1'b1;
            end
        end
    end

    always_ff @(posedge clk or negedge rstn) begin
        if (!rstn) begin
            scnt_q  <= '0;
            en_q    <= {NCH{DEF_EN}};
            sh_en_q <= {NCH{DEF_EN}};
            div_q   <= '0;
            tick_q  <= '0;
            pend_q  <= '0;
            for (int i = 0; i < NCH; i++) begin
                hcnt_q[i]    <= '0;
                act_div_q[i] <= DEF_DIV_V;
                sh_div_q[i]  <= DEF_DIV_V;
                phase_q[i]   <= '0;
            end
        end else begin
            scnt_q  <= scnt_d;
            en_q    <= en_d;
            sh_en_q <= sh_en_d;
            div_q   <= div_d;
            tick_q  <= tick_d;
            pend_q  <= pend_d;
            for (int i = 0; i < NCH; i++) begin
                hcnt_q[i]    <= hcnt_d[i];
                act_div_q[i] <= act_div_d[i];
                sh_div_q[i]  <= sh_div_d[i];
                phase_q[i]   <= phase_d[i];
            end
        end
    end

endmodule

// File: tb/tb_clk_div_bank.sv
// tb_clk_div_bank: self-checking bench for clk_div_bank.
// Event-time reference model: each channel tracks its last and next rise.
module tb_clk_div_bank;

    localparam int NCH     = 4;
    localparam int DIVW    = 8;
    localparam int RSTW    = 4;
    localparam int DEF_DIV = 3;
    localparam int SAT     = (1 << RSTW) - 1;
    localparam int INF     = 32'h7fff_ffff;
    localparam int VW      = 3 * NCH + 1;

    logic            clk = 1'b0;
    logic            rstn = 1'b0;
    logic            cfg_wr = 1'b0;
    logic [3:0]      cfg_ch = '0;
    logic [DIVW-1:0] cfg_div = '0;
    logic [DIVW-1:0] cfg_phase = '0;
    logic            cfg_en = 1'b0;
    logic            sync = 1'b0;
    logic [NCH-1:0]  div_out, tick, pend;
    logic            rst_out;

    int checks = 0;
    int errors = 0;
    int cyc = 0;

    // Model state: H = half period in cycles.
    int m_cnt;
    int m_h[NCH], m_en[NCH], m_pend[NCH];
    int s_h[NCH], s_en[NCH], s_ph[NCH];
    int nxt[NCH], last[NCH];
    bit lv[NCH];

    clk_div_bank #(
        .NCH(NCH), .DIVW(DIVW), .DEF_DIV(DEF_DIV),
        .DEF_EN(1'b1), .RSTW(RSTW)
    ) dut (
        .clk(clk), .rstn(rstn), .cfg_wr(cfg_wr), .cfg_ch(cfg_ch),
        .cfg_div(cfg_div), .cfg_phase(cfg_phase), .cfg_en(cfg_en),
        .sync(sync), .div_out(div_out), .tick(tick), .pend(pend),
        .rst_out(rst_out)
    );

    always #5 clk = ~clk;

    function automatic void model_reset();
        m_cnt = 0;
        for (int i = 0; i < NCH; i++) begin
            m_h[i] = DEF_DIV + 1;  s_h[i] = DEF_DIV + 1;
            m_en[i] = 1;           s_en[i] = 1;
            s_ph[i] = 0;           m_pend[i] = 0;
            nxt[i] = INF;          last[i] = 0;
            lv[i] = 1'b0;
        end
    endfunction

    function automatic void apply(int i);
        m_h[i] = s_h[i];
        m_en[i] = s_en[i];
        m_pend[i] = 0;
    endfunction

    function automatic void model_edge(int k);
        bit r;
        int p0, st;
        r = (m_cnt < SAT);
        for (int i = 0; i < NCH; i++) begin
            p0 = m_pend[i];
            if (cfg_wr && int'(cfg_ch) == i) begin
                s_h[i] = int'(cfg_div) + 1;
                s_ph[i] = int'(cfg_phase);
                s_en[i] = int'(cfg_en);
                m_pend[i] = 1;
            end
            if (r) begin
                lv[i] = 1'b0;
                nxt[i] = (m_en[i] != 0) ? k + m_h[i] : INF;
            end else if (sync) begin
                apply(i);
                lv[i] = 1'b0;
                st = (s_ph[i] < m_h[i] - 1) ? s_ph[i] : m_h[i] - 1;
                nxt[i] = (m_en[i] != 0) ? k + m_h[i] - st : INF;
            end else if (m_en[i] == 0) begin
                if (p0 != 0) begin
                    apply(i);
                    nxt[i] = (m_en[i] != 0) ? k + m_h[i] : INF;
                end
            end else if (k == nxt[i]) begin
                if (m_pend[i] != 0) apply(i);
                if (m_en[i] != 0) begin
                    lv[i] = 1'b1;
                    last[i] = k;
                    nxt[i] = k + 2 * m_h[i];
                end else begin
                    lv[i] = 1'b0;
                    nxt[i] = INF;
                end
            end
        end
        if (m_cnt < SAT) m_cnt++;
    endfunction

    function automatic logic [VW-1:0] exp_vec();
        logic [VW-1:0] v;
        v = '0;
        v[3*NCH] = (m_cnt < SAT);
        for (int i = 0; i < NCH; i++) begin
            v[2*NCH+i] = (m_pend[i] != 0);
            v[NCH+i] = lv[i] && (last[i] == cyc);
            v[i] = lv[i] && ((cyc - last[i]) < m_h[i]);
        end
        return v;
    endfunction

    task automatic step();
        @(posedge clk);
        cyc++;
        if (!rstn) model_reset();
        else model_edge(cyc);
        #1;
    endtask

    task automatic wr(int ch, int dv, int ph, bit en, bit sy);
        cfg_wr = 1'b1;
        cfg_ch = 4'(ch);
        cfg_div = DIVW'(dv);
        cfg_phase = DIVW'(ph);
        cfg_en = en;
        sync = sy;
        step();
        cfg_wr = 1'b0;
        sync = 1'b0;
    endtask

    task automatic test_reset();
        int fall, ft, hi, tk;
        logic [VW-1:0] got, want;
        fall = -1;
        ft = -1;
        rstn = 1'b0;
        model_reset();
        repeat (2) step();
        got = {rst_out, pend, tick, div_out};
        checks++;
        if (got !== {1'b1, {(3*NCH){1'b0}}}) begin
            errors++;
            $display("FAIL reset_state got=%h exp=%h", got,
                     {1'b1, {(3*NCH){1'b0}}});
        end
        rstn = 1'b1;
        for (int n = 1; n <= 40; n++) begin
            step();
            got = {rst_out, pend, tick, div_out};
            want = exp_vec();
            checks++;
            if (got !== want) begin
                errors++;
                $display("FAIL startup cyc=%0d got=%h exp=%h",
                         cyc, got, want);
            end
            if (fall < 0 && !rst_out) fall = n;
            if (ft < 0 && tick[0]) ft = n;
        end
        checks++;
        if (fall != SAT) begin
            errors++;
            $display("FAIL rst_fall got=%0d exp=%0d", fall, SAT);
        end
        checks++;
        if (ft - fall != DEF_DIV + 1) begin
            errors++;
            $display("FAIL first_tick got=%0d exp=%0d",
                     ft - fall, DEF_DIV + 1);
        end
        hi = 0;
        tk = 0;
        for (int n = 0; n < 16; n++) begin
            step();
            hi += int'(div_out[0]);
            tk += int'(tick[0]);
        end
        checks++;
        if (hi != 8 || tk != 2) begin
            errors++;
            $display("FAIL duty got=%0d/%0d exp=8/2", hi, tk);
        end
    endtask

    task automatic test_write_mid_high();
        int n, tk;
        logic [VW-1:0] got, want;
        n = 0;
        while (!tick[1] && n < 20) begin
            step();
            n++;
        end
        step();
        wr(1, 0, 0, 1'b1, 1'b0);
        n = 0;
        while (pend[1] && n < 20) begin
            step();
            n++;
            got = {rst_out, pend, tick, div_out};
            want = exp_vec();
            checks++;
            if (got !== want) begin
                errors++;
                $display("FAIL ratio_chg cyc=%0d got=%h exp=%h",
                         cyc, got, want);
            end
        end
        checks++;
        if (n != 6) begin
            errors++;
            $display("FAIL pend_clear got=%0d exp=6", n);
        end
        tk = 0;
        for (int k = 0; k < 8; k++) begin
            step();
            tk += int'(tick[1]);
            got = {rst_out, pend, tick, div_out};
            want = exp_vec();
            checks++;
            if (got !== want) begin
                errors++;
                $display("FAIL ratio2 cyc=%0d got=%h exp=%h",
                         cyc, got, want);
            end
        end
        checks++;
        if (tk != 4) begin
            errors++;
            $display("FAIL ratio2_ticks got=%0d exp=4", tk);
        end
    endtask

    task automatic test_double_write();
        int n, t1;
        logic [VW-1:0] got, want;
        wr(2, 5, 0, 1'b1, 1'b0);
        wr(2, 7, 0, 1'b1, 1'b0);
        n = 0;
        t1 = -1;
        while (n < 60) begin
            step();
            n++;
            got = {rst_out, pend, tick, div_out};
            want = exp_vec();
            checks++;
            if (got !== want) begin
                errors++;
                $display("FAIL dbl_wr cyc=%0d got=%h exp=%h",
                         cyc, got, want);
            end
            if (tick[2] && !pend[2]) begin
                if (t1 < 0) t1 = n;
                else break;
            end
        end
        checks++;
        if (n - t1 != 16) begin
            errors++;
            $display("FAIL dbl_period got=%0d exp=16", n - t1);
        end
        wr(9, 0, 0, 1'b0, 1'b0);
        checks++;
        if (pend !== '0) begin
            errors++;
            $display("FAIL bad_ch pend got=%b exp=0", pend);
        end
    endtask

    task automatic test_sync_phase();
        int f0, f3, l0, l3;
        logic [VW-1:0] got, want;
        f0 = -1; f3 = -1; l0 = -1; l3 = -1;
        wr(0, 3, 0, 1'b1, 1'b0);
        wr(3, 3, 2, 1'b1, 1'b0);
        sync = 1'b1;
        step();
        sync = 1'b0;
        for (int n = 1; n <= 14; n++) begin
            step();
            got = {rst_out, pend, tick, div_out};
            want = exp_vec();
            checks++;
            if (got !== want) begin
                errors++;
                $display("FAIL sync cyc=%0d got=%h exp=%h",
                         cyc, got, want);
            end
            if (tick[0]) begin
                if (f0 < 0) f0 = n;
                l0 = n;
            end
            if (tick[3]) begin
                if (f3 < 0) f3 = n;
                l3 = n;
            end
        end
        checks++;
        if (f3 != 2 || f0 != 4) begin
            errors++;
            $display("FAIL sync_first got=%0d,%0d exp=2,4", f3, f0);
        end
        checks++;
        if (l3 != 10 || l0 != 12) begin
            errors++;
            $display("FAIL sync_lead got=%0d,%0d exp=10,12", l3, l0);
        end
    endtask

    task automatic test_enable();
        int n, tk;
        logic [VW-1:0] got, want;
        wr(1, 2, 0, 1'b0, 1'b0);
        tk = 0;
        for (int k = 0; k < 20; k++) begin
            step();
            if (k >= 10) tk += int'(tick[1]) + int'(div_out[1]);
            got = {rst_out, pend, tick, div_out};
            want = exp_vec();
            checks++;
            if (got !== want) begin
                errors++;
                $display("FAIL disable cyc=%0d got=%h exp=%h",
                         cyc, got, want);
            end
        end
        checks++;
        if (tk != 0 || pend[1] !== 1'b0) begin
            errors++;
            $display("FAIL disabled_quiet got=%0d/%b exp=0/0",
                     tk, pend[1]);
        end
        wr(1, 2, 0, 1'b1, 1'b0);
        n = 0;
        while (!tick[1] && n < 20) begin
            step();
            n++;
        end
        // One cycle to apply, then cfg_div+1 cycles to the first rise.
        checks++;
        if (n != 4) begin
            errors++;
            $display("FAIL reenable got=%0d exp=4", n);
        end
    endtask

    task automatic test_random();
        logic [VW-1:0] got, want;
        for (int k = 0; k < 400; k++) begin
            cfg_wr = ($urandom_range(0, 5) == 0);
            cfg_ch = 4'($urandom_range(0, 9));
            cfg_div = DIVW'($urandom_range(0, 5));
            cfg_phase = DIVW'($urandom_range(0, 5));
            cfg_en = ($urandom_range(0, 4) != 0);
            sync = ($urandom_range(0, 24) == 0);
            step();
            cfg_wr = 1'b0;
            sync = 1'b0;
            got = {rst_out, pend, tick, div_out};
            want = exp_vec();
            checks++;
            if (got !== want) begin
                errors++;
                $display("FAIL random cyc=%0d got=%h exp=%h",
                         cyc, got, want);
            end
        end
    endtask

    task automatic test_sync_write_reset();
        int t1, t2, fall;
        logic [VW-1:0] got, want;
        for (int i = 0; i < NCH; i++) wr(i, 3, 0, 1'b1, 1'b0);
        t1 = -1;
        t2 = -1;
        wr(0, 1, 0, 1'b1, 1'b1);
        checks++;
        if (pend[0] !== 1'b0) begin
            errors++;
            $display("FAIL sync_wr_pend got=%b exp=0", pend[0]);
        end
        for (int n = 1; n <= 7; n++) begin
            step();
            got = {rst_out, pend, tick, div_out};
            want = exp_vec();
            checks++;
            if (got !== want) begin
                errors++;
                $display("FAIL sync_wr cyc=%0d got=%h exp=%h",
                         cyc, got, want);
            end
            if (tick[0]) begin
                if (t1 < 0) t1 = n;
                else if (t2 < 0) t2 = n;
            end
        end
        checks++;
        if (t1 != 2 || t2 != 6) begin
            errors++;
            $display("FAIL sync_wr_ticks got=%0d,%0d exp=2,6", t1, t2);
        end
        #3;
        rstn = 1'b0;
        model_reset();
        #1;
        got = {rst_out, pend, tick, div_out};
        checks++;
        if (got !== {1'b1, {(3*NCH){1'b0}}}) begin
            errors++;
            $display("FAIL async_rst got=%h exp=%h", got,
                     {1'b1, {(3*NCH){1'b0}}});
        end
        repeat (2) step();
        rstn = 1'b1;
        fall = -1;
        for (int n = 1; n <= 24; n++) begin
            step();
            got = {rst_out, pend, tick, div_out};
            want = exp_vec();
            checks++;
            if (got !== want) begin
                errors++;
                $display("FAIL restart cyc=%0d got=%h exp=%h",
                         cyc, got, want);
            end
            if (fall < 0 && !rst_out) fall = n;
        end
        checks++;
        if (fall != SAT) begin
            errors++;
            $display("FAIL restart_fall got=%0d exp=%0d", fall, SAT);
        end
    endtask

    initial begin
        test_reset();
        test_write_mid_high();
        test_double_write();
        test_sync_phase();
        test_enable();
        test_random();
        test_sync_write_reset();
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

    initial begin
        #1_000_000;
        $display("FAIL watchdog cyc=%0d exp=finish", cyc);
        $fatal(1, "timeout");
    end

endmodule
